// File: rtl/gorf_sample_server.sv
// Gorf speech-sample responder: serves 16-bit reads from 64-bit DDRAM lines
// through a single-line cache; all outputs are registered.
module gorf_sample_server #(
    parameter logic [28:0] BASE_ADDR = 29'h0600_0000
) (
    input  logic        CLK,
    input  logic        I_RESET_L,
    input  logic        s_enable,
    input  logic [23:0] s_addr,
    input  logic        s_read,
    output logic [15:0] s_data,
    output logic        s_ready,
    output logic        s_busy,
    output logic [28:0] DDRAM_ADDR,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic        DDRAM_RD,
    input  logic        DDRAM_BUSY,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [15:0] s_data_q, s_data_d;
    logic        s_ready_q, s_ready_d;
    logic        s_busy_q, s_busy_d;
    logic        rd_q, rd_d;
    logic [28:0] ddr_addr_q, ddr_addr_d;
    logic [63:0] line_q, line_d;
    logic [20:0] tag_q, tag_d;
    logic [20:0] req_tag_q, req_tag_d;
    logic        valid_q, valid_d;
    logic [1:0]  word_sel_q, word_sel_d;
    logic        abort_q, abort_d;
    logic        aborting;

    function automatic logic [15:0] word_of(input logic [63:0] line, input logic [1:0] sel);
        case (sel)
            2'd0:    word_of = line[15:0];
            2'd1:    word_of = line[31:16];
            2'd2:    word_of = line[47:32];
            default: word_of = line[63:48];
        endcase
    endfunction

    // Once s_enable drops mid-transaction the response is suppressed even if it returns.
    assign aborting = abort_q || !s_enable;

    always_comb begin
        state_d    = state_q;
        s_data_d   = s_data_q;
        s_ready_d  = 1'b0;
        s_busy_d   = s_busy_q;
        rd_d       = rd_q;
        ddr_addr_d = ddr_addr_q;
        line_d     = line_q;
        tag_d      = tag_q;
        req_tag_d  = req_tag_q;
        valid_d    = valid_q && s_enable;
        word_sel_d = word_sel_q;
        abort_d    = abort_q;

        unique case (state_q)
            StIdle: begin
                if (s_read && s_enable) begin
                    word_sel_d = s_addr[2:1];
                    req_tag_d  = s_addr[23:3];
                    if (valid_q && (tag_q == s_addr[23:3])) begin
                        s_data_d  = word_of(line_q, s_addr[2:1]);
                        s_ready_d = 1'b1;
                        state_d   = StResp;
                    end else begin
                        ddr_addr_d = BASE_ADDR + {8'b0, s_addr[23:3]};
                        rd_d       = 1'b1;
                        s_busy_d   = 1'b1;
                        abort_d    = 1'b0;
                        state_d    = StIssue;
                    end
                end
            end
            StIssue: begin
                abort_d = aborting;
                if (!DDRAM_BUSY) begin
                    rd_d    = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                abort_d = aborting;
                if (DDRAM_DOUT_READY) begin
                    line_d   = DDRAM_DOUT;
                    tag_d    = req_tag_q;
                    s_busy_d = 1'b0;
                    if (aborting) begin
                        state_d = StIdle;
                    end else begin
                        valid_d   = 1'b1;
                        s_data_d  = word_of(DDRAM_DOUT, word_sel_q);
                        s_ready_d = 1'b1;
                        state_d   = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state_q    <= StIdle;
            s_data_q   <= '0;
            s_ready_q  <= 1'b0;
            s_busy_q   <= 1'b0;
            rd_q       <= 1'b0;
            ddr_addr_q <= '0;
            line_q     <= '0;
            tag_q      <= '0;
            req_tag_q  <= '0;
            valid_q    <= 1'b0;
            word_sel_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_data_q   <= s_data_d;
            s_ready_q  <= s_ready_d;
            s_busy_q   <= s_busy_d;
            rd_q       <= rd_d;
            ddr_addr_q <= ddr_addr_d;
            line_q     <= line_d;
            tag_q      <= tag_d;
            req_tag_q  <= req_tag_d;
            valid_q    <= valid_d;
            word_sel_q <= word_sel_d;
            abort_q    <= abort_d;
        end
    end

    assign s_data         = s_data_q;
    assign s_ready        = s_ready_q;
    assign s_busy         = s_busy_q;
    assign DDRAM_RD       = rd_q;
    assign DDRAM_ADDR     = ddr_addr_q;
    assign DDRAM_BURSTCNT = 8'd1;

endmodule

// File: tb/tb_gorf_sample_server.sv
// Directed bench for gorf_sample_server: vector table for miss/hit timing,
// hand sequences for reset, stall, abort and protocol violation.
module tb_gorf_sample_server;

    logic        CLK = 1'b0;
    logic        I_RESET_L = 1'b0;
    logic        s_enable = 1'b0;
    logic [23:0] s_addr = '0;
    logic        s_read = 1'b0;
    logic [15:0] s_data;
    logic        s_ready;
    logic        s_busy;
    logic [28:0] DDRAM_ADDR;
    logic [7:0]  DDRAM_BURSTCNT;
    logic        DDRAM_RD;
    logic        DDRAM_BUSY = 1'b0;
    logic [63:0] DDRAM_DOUT = '0;
    logic        DDRAM_DOUT_READY = 1'b0;

    gorf_sample_server dut (
        .CLK              (CLK),
        .I_RESET_L        (I_RESET_L),
        .s_enable         (s_enable),
        .s_addr           (s_addr),
        .s_read           (s_read),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .s_busy           (s_busy),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic        rd;
        logic [23:0] addr;
        logic        busy;
        logic        dr;
        logic [63:0] dout;
        logic        exp_ready;
        logic [15:0] exp_data;
        logic        exp_rd;
        logic [28:0] exp_addr;
        logic        exp_busy;
    } vec_t;

    vec_t tbl[13];
    int   n_vec = 0;
    int   n_err = 0;
    int   rd_cnt, rdy_cnt, acc_cnt, addr_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick_cnt();
        tick();
        if (DDRAM_RD) rd_cnt++;
        if (s_ready) rdy_cnt++;
    endtask

    initial begin
        // Reset held with random inputs
        repeat (3) begin
            s_enable         = 1'($urandom);
            s_read           = 1'($urandom);
            s_addr           = 24'($urandom);
            DDRAM_BUSY       = 1'($urandom);
            DDRAM_DOUT_READY = 1'($urandom);
            DDRAM_DOUT       = {$urandom, $urandom};
            tick();
            check("rst_s_data", 64'(s_data), 64'h0);
            check("rst_s_ready", 64'(s_ready), 64'h0);
            check("rst_s_busy", 64'(s_busy), 64'h0);
            check("rst_ddram_rd", 64'(DDRAM_RD), 64'h0);
            check("rst_ddram_addr", 64'(DDRAM_ADDR), 64'h0);
        end
        s_enable = 1'b1; s_read = 1'b0; s_addr = '0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = '0;
        I_RESET_L = 1'b1;
        tick();
        check("burstcnt", 64'(DDRAM_BURSTCNT), 64'h1);
        s_read = 1'b1; s_addr = 24'h000000;
        tick();
        s_read = 1'b0;
        check("post_rst_miss_rd", 64'(DDRAM_RD), 64'h1);
        check("post_rst_miss_addr", 64'(DDRAM_ADDR), 64'h0600_0000);
        tick();
        DDRAM_DOUT_READY = 1'b1; DDRAM_DOUT = 64'hDDDD_CCCC_BBBB_AAAA;
        tick();
        DDRAM_DOUT_READY = 1'b0;
        check("post_rst_ready", 64'(s_ready), 64'h1);
        check("post_rst_data", 64'(s_data), 64'hAAAA);
        tick();

        // Miss at 0x12, hit at 0x16, miss at 0x18
        tbl[0]  = '{1'b1, 1'b1, 24'h12, 1'b0, 1'b0, 64'h0,
                    1'b0, 16'hAAAA, 1'b1, 29'h0600_0002, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 64'h0,
                    1'b0, 16'hAAAA, 1'b0, 29'h0600_0002, 1'b1};
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = tbl[1];
        tbl[5]  = '{1'b1, 1'b0, 24'h0, 1'b0, 1'b1, 64'h4444_3333_2222_1111,
                    1'b1, 16'h2222, 1'b0, 29'h0600_0002, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 64'h0,
                    1'b0, 16'h2222, 1'b0, 29'h0600_0002, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 24'h16, 1'b0, 1'b0, 64'h0,
                    1'b1, 16'h4444, 1'b0, 29'h0600_0002, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 64'h0,
                    1'b0, 16'h4444, 1'b0, 29'h0600_0002, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 24'h18, 1'b0, 1'b0, 64'h0,
                    1'b0, 16'h4444, 1'b1, 29'h0600_0003, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 64'h0,
                    1'b0, 16'h4444, 1'b0, 29'h0600_0003, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 24'h0, 1'b0, 1'b1, 64'h8888_7777_6666_5555,
                    1'b1, 16'h5555, 1'b0, 29'h0600_0003, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 64'h0,
                    1'b0, 16'h5555, 1'b0, 29'h0600_0003, 1'b0};

        for (int i = 0; i < 13; i++) begin
            s_enable = tbl[i].en; s_read = tbl[i].rd; s_addr = tbl[i].addr;
            DDRAM_BUSY = tbl[i].busy; DDRAM_DOUT_READY = tbl[i].dr; DDRAM_DOUT = tbl[i].dout;
            tick();
            check($sformatf("v%0d_ready", i), 64'(s_ready), 64'(tbl[i].exp_ready));
            check($sformatf("v%0d_data", i), 64'(s_data), 64'(tbl[i].exp_data));
            check($sformatf("v%0d_rd", i), 64'(DDRAM_RD), 64'(tbl[i].exp_rd));
            check($sformatf("v%0d_addr", i), 64'(DDRAM_ADDR), 64'(tbl[i].exp_addr));
            check($sformatf("v%0d_busy", i), 64'(s_busy), 64'(tbl[i].exp_busy));
        end
        s_read = 1'b0; DDRAM_DOUT_READY = 1'b0;

        // Stall: arbiter busy for the first three issue cycles
        s_read = 1'b1; s_addr = 24'h000044; DDRAM_BUSY = 1'b1;
        tick();
        s_read = 1'b0;
        rd_cnt = 0; acc_cnt = 0; addr_bad = 0;
        for (int c = 0; c < 20 && DDRAM_RD; c++) begin
            rd_cnt++;
            if (DDRAM_ADDR !== 29'h0600_0008) addr_bad++;
            DDRAM_BUSY = (c < 3);
            if (!DDRAM_BUSY) acc_cnt++;
            tick();
        end
        DDRAM_BUSY = 1'b0;
        check("stall_rd_cycles", 64'(rd_cnt), 64'd4);
        check("stall_accepts", 64'(acc_cnt), 64'd1);
        check("stall_addr_stable", 64'(addr_bad), 64'd0);
        tick();
        DDRAM_DOUT_READY = 1'b1; DDRAM_DOUT = 64'h0123_4567_89AB_CDEF;
        rd_cnt = 0; rdy_cnt = 0;
        tick_cnt();
        DDRAM_DOUT_READY = 1'b0;
        repeat (4) tick_cnt();
        check("stall_ready_count", 64'(rdy_cnt), 64'd1);
        check("stall_data", 64'(s_data), 64'h4567);

        // Abort: s_enable dropped during WAIT
        s_read = 1'b1; s_addr = 24'h000080;
        tick();
        s_read = 1'b0;
        tick();
        s_enable = 1'b0;
        tick();
        check("abort_busy_wait", 64'(s_busy), 64'h1);
        DDRAM_DOUT_READY = 1'b1; DDRAM_DOUT = 64'hFFFF_EEEE_DDDD_9999;
        rd_cnt = 0; rdy_cnt = 0;
        tick_cnt();
        DDRAM_DOUT_READY = 1'b0;
        repeat (3) tick_cnt();
        check("abort_no_ready", 64'(rdy_cnt), 64'd0);
        check("abort_busy_clear", 64'(s_busy), 64'h0);
        s_enable = 1'b1; s_read = 1'b1; s_addr = 24'h000080;
        tick();
        s_read = 1'b0;
        check("abort_refetch_rd", 64'(DDRAM_RD), 64'h1);
        check("abort_refetch_addr", 64'(DDRAM_ADDR), 64'h0600_0010);
        tick();
        DDRAM_DOUT_READY = 1'b1;
        tick();
        DDRAM_DOUT_READY = 1'b0;
        check("abort_refetch_data", 64'(s_data), 64'h9999);
        tick();

        // Violation: second s_read while a miss is outstanding
        rd_cnt = 0; rdy_cnt = 0;
        s_read = 1'b1; s_addr = 24'h0000C0;
        tick_cnt();
        s_read = 1'b0;
        tick_cnt();
        s_read = 1'b1; s_addr = 24'h0000C8;
        tick_cnt();
        s_read = 1'b0;
        tick_cnt();
        DDRAM_DOUT_READY = 1'b1; DDRAM_DOUT = 64'h1357_2468_ACE0_BEEF;
        tick_cnt();
        DDRAM_DOUT_READY = 1'b0;
        repeat (6) tick_cnt();
        check("viol_rd_count", 64'(rd_cnt), 64'd1);
        check("viol_ready_count", 64'(rdy_cnt), 64'd1);
        check("viol_data", 64'(s_data), 64'hBEEF);
        check("viol_busy_clear", 64'(s_busy), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gorf_sample_server.md
# gorf_sample_server

Responder for the Gorf speech-sample fetch interface. Answers one-word read requests (`s_read` / `s_addr`) issued by the Gorf sound block, fetching 64-bit lines from DDRAM and returning the 16-bit word with a one-cycle `s_ready` strobe. A single-line cache lets sequential sample reads inside the same 8-byte line complete without a DDRAM access. Sits between the Gorf sound block and the DDRAM arbiter port in the non-framebuffer build.

## Interface
- `BASE_ADDR`, 29'h0600_0000: DDRAM base of the sample region, in 64-bit-word units.
- `CLK` in 1: system clock; also the DDRAM port clock.
- `I_RESET_L` in 1: reset. Asynchronous, active-low.
- `s_enable` in 1: samples loaded and valid. Low = invalidate cache and suppress responses.
- `s_addr` in 24: byte address of the requested word. Bit 0 is ignored.
- `s_read` in 1: one-cycle request strobe, qualified by `s_enable`.
- `s_data` out 16: returned sample word. Held until the next response.
- `s_ready` out 1: one-cycle strobe; `s_data` is valid in the same cycle.
- `s_busy` out 1: high from request acceptance until `s_ready` (or abort).
- `DDRAM_ADDR` out 29: line address, `BASE_ADDR + s_addr[23:3]`.
- `DDRAM_BURSTCNT` out 8: constant 1.
- `DDRAM_RD` out 1: read request. Held until accepted.
- `DDRAM_BUSY` in 1: arbiter stall.
- `DDRAM_DOUT` in 64: read data.
- `DDRAM_DOUT_READY` in 1: read-data valid strobe.

## Operation
- **Reset state:** `s_data`=0, `s_ready`=0, `s_busy`=0, `DDRAM_RD`=0, `DDRAM_ADDR`=0. Cache valid bit cleared. FSM in IDLE.
- **Request acceptance:** a request is accepted in IDLE when `s_read && s_enable`. `s_addr` is latched in that cycle.
  - A request with `s_read` high while `s_busy` is high is a protocol violation. It is dropped and never answered.
- **Tag compare:** compare `s_addr[23:3]` with the cached tag.
  - Hit (tag match and cache valid): go to RESP.
  - Miss: go to ISSUE.
- **ISSUE:** drive `DDRAM_RD`=1 with `DDRAM_ADDR` stable. The read is accepted in the first cycle `DDRAM_BUSY`=0. In the next cycle `DDRAM_RD`=0 and the FSM moves to WAIT.
- **WAIT:** on `DDRAM_DOUT_READY`, load the line register with `DDRAM_DOUT`, set the tag, set valid, then go to RESP.
- **RESP:** select the word by `addr[2:1]`: 00 → `DOUT[15:0]`, 01 → `[31:16]`, 10 → `[47:32]`, 11 → `[63:48]`.
  - Drive `s_data` with the selected word and pulse `s_ready` for one cycle.
  - Clear `s_busy` and return to IDLE.
- **`s_enable` low:**
  - Valid is cleared every cycle.
  - In IDLE, requests are ignored.
  - During ISSUE, `DDRAM_RD` stays held until accepted. No read is ever withdrawn.
  - During WAIT, the FSM still consumes `DDRAM_DOUT_READY` but does not set valid.
  - The transaction ends in IDLE without `s_ready`. `s_busy` clears when the FSM returns to IDLE.
- **Reset mid-transaction:** the FSM returns to IDLE immediately. The arbiter is reset on the same reset, so no orphaned `DOUT_READY` needs handling.
- **Address arithmetic:** the 29-bit add wraps modulo 2^29 with no overflow flag. `s_addr[23:3]` is zero-extended to 29 bits before the add.

## Timing
- Request at cycle T.
- **Hit:** `s_ready` at T+1. Zero DDRAM activity.
- **Miss with no stall:**
  - `DDRAM_RD`=1 at T+1, accepted at T+1.
  - If `DDRAM_DOUT_READY` arrives at T+k, `s_ready` comes at T+k+1.
- **Each stall cycle** (`DDRAM_BUSY`=1 while `DDRAM_RD`=1) delays acceptance by one cycle. `DDRAM_ADDR` is unchanged throughout.
- **Back-to-back:** the earliest next accepted request is in the cycle after `s_ready` is seen (IDLE). A hit stream therefore gives one word every 2 cycles.
- **Registers:** all outputs are registered. No combinational path from any input to any output.

## Test plan
- **Reset:** hold `I_RESET_L`=0 with random inputs.
  - Required: all outputs 0. After release, the first request at 24'h000000 is a miss (`DDRAM_RD` asserted).
- **Miss:** `s_addr`=24'h000012 at T, `DDRAM_BUSY`=0, and `DDRAM_DOUT`=64'h4444_3333_2222_1111 with `DOUT_READY` at T+5.
  - Required: `DDRAM_ADDR`=29'h0600_0002 with `DDRAM_RD` for exactly cycle T+1.
  - Required: `s_ready` at T+6 with `s_data`=16'h2222.
- **Hit:** after the miss case, request `s_addr`=24'h000016.
  - Required: `s_ready` the next cycle, `s_data`=16'h4444, `DDRAM_RD` never asserted.
  - Then request 24'h000018. Required: a miss with `DDRAM_ADDR`=29'h0600_0003.
- **Stall:** `DDRAM_BUSY`=1 for 3 cycles on a miss.
  - Required: `DDRAM_RD` high for 4 cycles with a constant address, exactly one acceptance, one `s_ready`.
- **Abort:** drop `s_enable` during WAIT, then deliver `DOUT_READY`.
  - Required: no `s_ready` and `s_busy` clears.
  - Then re-enable and request the same line. Required: it misses (new `DDRAM_RD`).
- **Violation:** pulse `s_read` at T+2 while a miss is outstanding.
  - Required: exactly one `s_ready` (for the first request) and one `DDRAM_RD`.
